// File: rtl/i2s_master_tx.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_master_tx
//  Purpose  : I2S bus master / transmitter. Buffers one stereo 16-bit sample
//             pair from two Avalon-ST sinks, generates BCLK/LRCK from the
//             system clock and sends each pair MSB-first in I2S format.
//  Revision : 1.0  initial release
// ============================================================================
module i2s_master_tx #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic [15:0] left_input_data,
  input  logic        left_input_valid,
  output logic        left_input_ready,
  input  logic [15:0] right_input_data,
  input  logic        right_input_valid,
  output logic        right_input_ready,
  output logic        ext_BCLK,
  output logic        ext_DACLRCK,
  output logic        ext_DACDAT,
  output logic        underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DW         = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] LR_START = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] R_START  = BW'(SLOT_BITS);
  localparam logic [BW-1:0] WORD_LEN = BW'(16);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_idx;
  logic [15:0]   left_buf, right_buf;
  logic          left_full, right_full;
  // Words being sent in the current frame; indexed by bit position.
  logic [15:0]   left_shift, right_shift;

  logic          tick, fall, frame_start, load_ok;
  logic [BW-1:0] next_idx, ridx;
  logic [15:0]   left_word, right_word;
  logic [3:0]    lsel, rsel;
  logic          next_lrck, next_dat, in_left, in_right;

  assign left_input_ready  = ~left_full;
  assign right_input_ready = ~right_full;

  // Divider terminal count, BCLK fall detection and next-bit data selection.
  always_comb begin
    tick        = enable && (div_cnt == DIV_LAST);
    fall        = tick && ext_BCLK;
    next_idx    = (bit_idx == B_LAST) ? '0 : bit_idx + 1'b1;
    frame_start = fall && (next_idx == '0);
    load_ok     = left_full && right_full;
    // A frame start replaces the words being sent; zeros on underrun.
    left_word   = frame_start ? (load_ok ? left_buf  : 16'h0000) : left_shift;
    right_word  = frame_start ? (load_ok ? right_buf : 16'h0000) : right_shift;
    ridx        = next_idx - R_START;
    in_left     = (next_idx < WORD_LEN);
    in_right    = (next_idx >= R_START) && (ridx < WORD_LEN);
    lsel        = 4'd15 - next_idx[3:0];
    rsel        = 4'd15 - ridx[3:0];
    next_dat    = 1'b0;
    if (in_left) begin
      next_dat = left_word[lsel];
    end else if (in_right) begin
      next_dat = right_word[rsel];
    end
    // LRCK leads each channel's MSB by one bit clock.
    next_lrck   = (next_idx >= LR_START) && (next_idx != B_LAST);
  end

  // Serial clock generation, bit counter and registered bus outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt     <= '0;
      bit_idx     <= B_LAST;
      ext_BCLK    <= 1'b0;
      ext_DACLRCK <= 1'b0;
      ext_DACDAT  <= 1'b0;
      underrun    <= 1'b0;
      left_shift  <= '0;
      right_shift <= '0;
    end else if (!enable) begin
      // Idle bus; the next enable restarts from a fresh frame.
      div_cnt     <= '0;
      bit_idx     <= B_LAST;
      ext_BCLK    <= 1'b0;
      ext_DACLRCK <= 1'b0;
      ext_DACDAT  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      underrun <= frame_start && !load_ok;
      if (tick) begin
        div_cnt  <= '0;
        ext_BCLK <= ~ext_BCLK;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end
      if (fall) begin
        bit_idx     <= next_idx;
        ext_DACLRCK <= next_lrck;
        ext_DACDAT  <= next_dat;
        left_shift  <= left_word;
        right_shift <= right_word;
      end
    end
  end

  // Left holding buffer: fill on handshake, drain at a complete frame start.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      left_buf  <= '0;
      left_full <= 1'b0;
    end else if (left_input_valid && !left_full) begin
      left_buf  <= left_input_data;
      left_full <= 1'b1;
    end else if (frame_start && load_ok) begin
      left_full <= 1'b0;
    end
  end

  // Right holding buffer: same policy as the left one.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      right_buf  <= '0;
      right_full <= 1'b0;
    end else if (right_input_valid && !right_full) begin
      right_buf  <= right_input_data;
      right_full <= 1'b1;
    end else if (frame_start && load_ok) begin
      right_full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_master_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_i2s_master_tx
//  Purpose  : Directed, table-driven bench for i2s_master_tx (16- and 24-bit
//             slot instances) with hand-computed expected frames.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2s_master_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en16, en24, sel24;
  logic [15:0] ldata, rdata;
  logic        lv16, rv16, lv24, rv24;
  logic        lr16, rr16, bclk16, lrck16, dat16, ur16;
  logic        lr24, rr24, bclk24, lrck24, dat24, ur24;
  logic        m_bclk, m_lrck, m_dat, m_ur, m_lr, m_rr;

  i2s_master_tx #(.BCLK_DIV(4), .SLOT_BITS(16)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(en16),
    .left_input_data(ldata), .left_input_valid(lv16), .left_input_ready(lr16),
    .right_input_data(rdata), .right_input_valid(rv16), .right_input_ready(rr16),
    .ext_BCLK(bclk16), .ext_DACLRCK(lrck16), .ext_DACDAT(dat16), .underrun(ur16));

  i2s_master_tx #(.BCLK_DIV(4), .SLOT_BITS(24)) dut24 (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(en24),
    .left_input_data(ldata), .left_input_valid(lv24), .left_input_ready(lr24),
    .right_input_data(rdata), .right_input_valid(rv24), .right_input_ready(rr24),
    .ext_BCLK(bclk24), .ext_DACLRCK(lrck24), .ext_DACDAT(dat24), .underrun(ur24));

  // Observation mux: the tasks look at whichever instance is under test.
  assign m_bclk = sel24 ? bclk24 : bclk16;
  assign m_lrck = sel24 ? lrck24 : lrck16;
  assign m_dat  = sel24 ? dat24  : dat16;
  assign m_ur   = sel24 ? ur24   : ur16;
  assign m_lr   = sel24 ? lr24   : lr16;
  assign m_rr   = sel24 ? rr24   : rr16;

  int n_chk  = 0;
  int n_pass = 0;
  int ur_cnt = 0;

  typedef struct {
    logic        pl, pr;
    logic [15:0] l, r;
    logic [31:0] exp_dat;
    logic        exp_ur, exp_lr, exp_rr;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance n falling clock edges, counting underrun pulses seen.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (m_ur === 1'b1) ur_cnt++;
    end
  endtask

  // Offer samples for one cycle; spans exactly 7 falling edges.
  task automatic push_gap(input logic pl, input logic pr, input logic [15:0] l, input logic [15:0] r);
    ur_cnt = 0;
    ldata = l;
    rdata = r;
    if (sel24) begin lv24 = pl; rv24 = pr; end
    else       begin lv16 = pl; rv16 = pr; end
    step(1);
    lv16 = 1'b0; rv16 = 1'b0; lv24 = 1'b0; rv24 = 1'b0;
    if (pl) chk("left_ready_fell", {63'd0, m_lr}, 64'd0);
    if (pr) chk("right_ready_fell", {63'd0, m_rr}, 64'd0);
    step(6);
  endtask

  // Sample one frame at each BCLK fall (first fall after first_wait edges).
  task automatic capture(input int slot, input int first_wait,
                         output logic [63:0] dat, output logic [63:0] lrck,
                         output logic bclk_ok, output logic lr0, output logic rr0);
    dat = '0; lrck = '0; bclk_ok = 1'b1; lr0 = 1'b0; rr0 = 1'b0;
    for (int k = 0; k < 2 * slot; k++) begin
      if (k == 0) step(first_wait);
      else begin
        step(4);
        if (m_bclk !== 1'b1) bclk_ok = 1'b0;
        step(4);
      end
      if (m_bclk !== 1'b0) bclk_ok = 1'b0;
      dat[2*slot-1-k]  = m_dat;
      lrck[2*slot-1-k] = m_lrck;
      if (k == 0) begin lr0 = m_lr; rr0 = m_rr; end
    end
  endtask

  initial begin
    logic [63:0] cd, cl;
    logic        bok, lr0, rr0;

    vecs[0] = '{1'b1, 1'b1, 16'hA5C3, 16'h1234, 32'hA5C3_1234, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'h8001, 16'h0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 16'h7FFF, 32'h8001_7FFF, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 32'hFFFF_0000, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 16'h0001, 16'h8000, 32'h0001_8000, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0; en16 = 1'b0; en24 = 1'b0; sel24 = 1'b0;
    ldata = '0; rdata = '0; lv16 = 1'b0; rv16 = 1'b0; lv24 = 1'b0; rv24 = 1'b0;
    step(2);
    chk("reset16", {58'd0, bclk16, lrck16, dat16, ur16, lr16, rr16}, 64'b000011);
    chk("reset24", {58'd0, bclk24, lrck24, dat24, ur24, lr24, rr24}, 64'b000011);
    rst_n = 1'b1;
    step(2);

    // Back-to-back frames on the 16-bit slot instance.
    en16 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_gap(vecs[i].pl, vecs[i].pr, vecs[i].l, vecs[i].r);
      capture(16, 1, cd, cl, bok, lr0, rr0);
      chk($sformatf("v%0d_dat", i), cd, {32'd0, vecs[i].exp_dat});
      chk($sformatf("v%0d_lrck", i), cl, 64'h0000_0000_0001_FFFE);
      chk($sformatf("v%0d_underrun", i), 64'(ur_cnt), {63'd0, vecs[i].exp_ur});
      chk($sformatf("v%0d_bclk", i), {63'd0, bok}, 64'd1);
      chk($sformatf("v%0d_lready", i), {63'd0, lr0}, {63'd0, vecs[i].exp_lr});
      chk($sformatf("v%0d_rready", i), {63'd0, rr0}, {63'd0, vecs[i].exp_rr});
    end

    // Disable mid-frame at b=10, with a second pair buffered meanwhile.
    push_gap(1'b1, 1'b1, 16'hA5C3, 16'h1234);
    step(1);
    chk("dis_b0_dat", {63'd0, dat16}, 64'd1);
    ldata = 16'h3C5A; rdata = 16'h0F0F; lv16 = 1'b1; rv16 = 1'b1;
    step(1);
    lv16 = 1'b0; rv16 = 1'b0;
    step(83);
    chk("dis_pre_bclk", {63'd0, bclk16}, 64'd1);
    en16 = 1'b0;
    ur_cnt = 0;
    step(1);
    chk("dis_outputs", {61'd0, bclk16, lrck16, dat16}, 64'd0);
    chk("dis_retained", {62'd0, lr16, rr16}, 64'd0);
    step(5);
    en16 = 1'b1;
    capture(16, 8, cd, cl, bok, lr0, rr0);
    chk("reen_dat", cd, 64'h0000_0000_3C5A_0F0F);
    chk("reen_lrck", cl, 64'h0000_0000_0001_FFFE);
    chk("reen_bclk", {63'd0, bok}, 64'd1);
    chk("reen_underrun", 64'(ur_cnt), 64'd0);

    // Asynchronous reset between clock edges while BCLK is high.
    ldata = 16'hFFFF; lv16 = 1'b1;
    step(1);
    lv16 = 1'b0;
    step(3);
    chk("arst_pre", {62'd0, bclk16, lr16}, 64'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {59'd0, bclk16, lrck16, dat16, lr16, rr16}, 64'b00011);
    en16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    // 24-bit slots: 16 data bits then 8 zero bits per channel.
    sel24 = 1'b1;
    en24 = 1'b1;
    push_gap(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    capture(24, 1, cd, cl, bok, lr0, rr0);
    chk("s24_dat", cd, 64'h0000_FFFF_00FF_FF00);
    chk("s24_lrck", cl, 64'h0000_0000_01FF_FFFE);
    chk("s24_underrun", 64'(ur_cnt), 64'd0);
    chk("s24_bclk", {63'd0, bok}, 64'd1);
    en24 = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
